// File: rtl/uart_echo_buf.sv
// uart_echo_buf: UART RX deserializer -> byte FIFO -> UART TX serializer echo engine
// with optional case conversion, TX hold and sticky overflow/framing flags.
module uart_echo_buf #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CASE_MODE  = 0
) (
  input  logic                        CLK_IN,
  input  logic                        RESET_IN,
  input  logic                        RX,
  output logic                        TX,
  input  logic                        ECHO_EN,
  input  logic                        TX_HOLD,
  input  logic                        CLR_FLAGS,
  output logic                        OVERFLOW,
  output logic                        FRAME_ERR,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CW-1:0] FULL_BIT = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(DIV / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t rx_st, rx_nx, tx_st, tx_nx;
  logic rx_meta, rx_s, rx_d, rx_fall;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [BW-1:0] rx_bit, tx_bit;
  logic [DATA_BITS-1:0] rx_sh, tx_sh, head, conv;
  logic [7:0] h8;
  logic rx_tick, tx_tick, rx_sample, stop_ok, stop_bad, push_req;
  logic push, pop, wr, empty, full;
  logic [AW:0] wptr, rptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  always_ff @(posedge CLK_IN or posedge RESET_IN)
    if (RESET_IN) {rx_meta, rx_s, rx_d} <= '1;
    else {rx_meta, rx_s, rx_d} <= {RX, rx_meta, rx_s};
  assign rx_fall = rx_d & ~rx_s;
  assign rx_tick = rx_cnt == '0;
  always_ff @(posedge CLK_IN or posedge RESET_IN)
    if (RESET_IN) rx_st <= IDLE;
    else rx_st <= rx_nx;
  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      IDLE:  rx_nx = rx_fall ? START : IDLE;
      START: rx_nx = !rx_tick ? START : rx_s ? IDLE : DATA;
      DATA:  rx_nx = (rx_tick && rx_bit == LAST_BIT) ? STOP : DATA;
      STOP:  rx_nx = rx_tick ? IDLE : STOP;
    endcase
  end
  always_comb begin
    rx_sample = rx_st == DATA && rx_tick;
    stop_ok   = rx_st == STOP && rx_tick && rx_s;
    stop_bad  = rx_st == STOP && rx_tick && !rx_s;
  end
  // Idle keeps the half-bit preload so START measures DIV/2 cycles from the edge.
  always_ff @(posedge CLK_IN or posedge RESET_IN)
    if (RESET_IN) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      push_req <= 1'b0;
    end else begin
      rx_cnt   <= rx_st == IDLE ? HALF_BIT : rx_tick ? FULL_BIT : rx_cnt - CW'(1);
      rx_bit   <= rx_st != DATA ? '0 : rx_tick ? rx_bit + BW'(1) : rx_bit;
      rx_sh    <= rx_sample ? {rx_s, rx_sh[DATA_BITS-1:1]} : rx_sh;
      push_req <= stop_ok;
    end
  assign push  = push_req & ECHO_EN;
  assign empty = wptr == rptr;
  assign full  = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
  assign wr    = push && (!full || pop);
  assign head  = mem[rptr[AW-1:0]];
  always_ff @(posedge CLK_IN)
    if (wr) mem[wptr[AW-1:0]] <= rx_sh;
  always_ff @(posedge CLK_IN or posedge RESET_IN)
    if (RESET_IN) begin
      wptr       <= '0;
      rptr       <= '0;
      FIFO_LEVEL <= '0;
    end else begin
      wptr       <= wr ? wptr + LW'(1) : wptr;
      rptr       <= pop ? rptr + LW'(1) : rptr;
      FIFO_LEVEL <= FIFO_LEVEL + LW'(wr) - LW'(pop);
    end
  always_ff @(posedge CLK_IN or posedge RESET_IN)
    if (RESET_IN) begin
      OVERFLOW  <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      OVERFLOW  <= CLR_FLAGS ? 1'b0 : (push && full && !pop) ? 1'b1 : OVERFLOW;
      FRAME_ERR <= CLR_FLAGS ? 1'b0 : stop_bad ? 1'b1 : FRAME_ERR;
    end
  assign h8 = 8'(head);
  assign conv = (DATA_BITS == 8 && CASE_MODE == 1 && h8 >= 8'h61 && h8 <= 8'h7A) ||
                (DATA_BITS == 8 && CASE_MODE == 2 && h8 >= 8'h41 && h8 <= 8'h5A)
                ? DATA_BITS'(h8 ^ 8'h20) : head;
  assign tx_tick = tx_cnt == '0;
  always_ff @(posedge CLK_IN or posedge RESET_IN)
    if (RESET_IN) tx_st <= IDLE;
    else tx_st <= tx_nx;
  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      IDLE:  tx_nx = pop ? START : IDLE;
      START: tx_nx = tx_tick ? DATA : START;
      DATA:  tx_nx = (tx_tick && tx_bit == LAST_BIT) ? STOP : DATA;
      STOP:  tx_nx = tx_tick ? IDLE : STOP;
    endcase
  end
  always_comb begin
    pop = tx_st == IDLE && !empty && !TX_HOLD;
    TX  = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : 1'b1;
  end
  always_ff @(posedge CLK_IN or posedge RESET_IN)
    if (RESET_IN) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      tx_cnt <= (tx_st == IDLE || tx_tick) ? FULL_BIT : tx_cnt - CW'(1);
      tx_bit <= tx_st != DATA ? '0 : tx_tick ? tx_bit + BW'(1) : tx_bit;
      tx_sh  <= pop ? conv : (tx_st == DATA && tx_tick) ? tx_sh >> 1 : tx_sh;
    end
endmodule

// File: tb/tb_uart_echo_buf.sv
// tb_uart_echo_buf: directed echo tests on three configurations (verbatim/16, upper/4, lower/2)
module tb_uart_echo_buf;
  localparam int CLK_HZ = 6_400_000;
  localparam int BAUD = 100_000;
  localparam int DIV = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] rx = '1;
  logic [2:0] hold = '0;
  logic echo_en = 1'b1;
  logic clr = 1'b0;
  wire [2:0] tx, ovf, ferr;
  wire [4:0] lev0;
  wire [2:0] lev1;
  wire [1:0] lev2;
  int checks = 0;
  int errors = 0;
  logic [7:0] got [3][32];
  int ng [3] = '{default: 0};
  int max0 = 0;
  int base0, base1, k;
  always #5 clk = ~clk;
  uart_echo_buf #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .FIFO_DEPTH(16), .CASE_MODE(0)) u0 (
    .CLK_IN(clk), .RESET_IN(rst), .RX(rx[0]), .TX(tx[0]), .ECHO_EN(echo_en), .TX_HOLD(hold[0]),
    .CLR_FLAGS(clr), .OVERFLOW(ovf[0]), .FRAME_ERR(ferr[0]), .FIFO_LEVEL(lev0));
  uart_echo_buf #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .FIFO_DEPTH(4), .CASE_MODE(1)) u1 (
    .CLK_IN(clk), .RESET_IN(rst), .RX(rx[1]), .TX(tx[1]), .ECHO_EN(echo_en), .TX_HOLD(hold[1]),
    .CLR_FLAGS(clr), .OVERFLOW(ovf[1]), .FRAME_ERR(ferr[1]), .FIFO_LEVEL(lev1));
  uart_echo_buf #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .FIFO_DEPTH(2), .CASE_MODE(2)) u2 (
    .CLK_IN(clk), .RESET_IN(rst), .RX(rx[2]), .TX(tx[2]), .ECHO_EN(echo_en), .TX_HOLD(hold[2]),
    .CLR_FLAGS(clr), .OVERFLOW(ovf[2]), .FRAME_ERR(ferr[2]), .FIFO_LEVEL(lev2));
  always @(negedge clk) if (int'(lev0) > max0) max0 <= int'(lev0);
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic mon(input int ch);
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && tx[ch] == 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx[ch];
        end
        repeat (DIV) @(negedge clk);
        if (tx[ch] && ng[ch] < 32) begin
          got[ch][ng[ch]] = b;
          ng[ch]++;
        end
      end
    end
  endtask
  task automatic send(input int ch, input logic [7:0] b, input logic stop = 1'b1);
    @(negedge clk);
    rx[ch] = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx[ch] = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx[ch] = stop;
    repeat (DIV) @(negedge clk);
    rx[ch] = 1'b1;
  endtask
  task automatic wait_n(input int ch, input int n, input int lim);
    for (int i = 0; i < lim && ng[ch] < n; i++) @(negedge clk);
  endtask
  initial begin
    fork
      mon(0);
      mon(1);
      mon(2);
    join_none
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx), 3'b111);
    chk("rst_lev", int'(lev0) + int'(lev1) + int'(lev2), 0);
    chk("rst_flags", int'({ovf, ferr}), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) send(0, 8'(8'h41 + i));
    wait_n(0, 5, 20 * DIV);
    chk("t1_count", ng[0], 5);
    for (int i = 0; i < 5; i++) chk("t1_byte", int'(got[0][i]), 8'h41 + i);
    chk("t1_maxlev_le1", int'(max0 <= 1), 1);
    chk("t1_flags", int'({ovf[0], ferr[0]}), 0);
    send(1, 8'h61);
    send(1, 8'h31);
    wait_n(1, 2, 30 * DIV);
    chk("t2_upper_a", int'(got[1][0]), 8'h41);
    chk("t2_upper_1", int'(got[1][1]), 8'h31);
    send(2, 8'h5A);
    wait_n(2, 1, 30 * DIV);
    chk("t2_lower_Z", int'(got[2][0]), 8'h7A);
    base0 = ng[0];
    send(0, 8'h55, 1'b0);
    repeat (20 * DIV) @(negedge clk);
    chk("t3_ferr_set", int'(ferr[0]), 1);
    chk("t3_no_tx", ng[0], base0);
    chk("t3_lev", int'(lev0), 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("t3_ferr_clr", int'(ferr[0]), 0);
    hold[1] = 1'b1;
    for (int i = 0; i < 6; i++) send(1, 8'(8'h31 + i));
    repeat (10) @(negedge clk);
    chk("t4_lev_full", int'(lev1), 4);
    chk("t4_ovf", int'(ovf[1]), 1);
    chk("t4_no_tx_held", ng[1], 2);
    hold[1] = 1'b0;
    wait_n(1, 6, 60 * DIV);
    repeat (25 * DIV) @(negedge clk);
    chk("t4_count", ng[1], 6);
    for (int i = 0; i < 4; i++) chk("t4_byte", int'(got[1][2 + i]), 8'h31 + i);
    chk("t4_lev_empty", int'(lev1), 0);
    base0 = ng[0];
    rx[0] = 1'b0;
    repeat (20) @(negedge clk);
    rx[0] = 1'b1;
    repeat (20 * DIV) @(negedge clk);
    chk("t5_no_byte", ng[0], base0);
    chk("t5_lev", int'(lev0), 0);
    chk("t5_flags", int'({ovf[0], ferr[0]}), 0);
    hold[1] = 1'b1;
    send(1, 8'h40);
    repeat (4) @(negedge clk);
    chk("t6_ch1_queued", int'(lev1), 1);
    base1 = ng[1];
    fork
      send(0, 8'h51);
      begin
        k = 0;
        while (tx[0] && k < 40 * DIV) begin
          @(negedge clk);
          k++;
        end
        chk("t6_tx_start", int'(tx[0]), 0);
        repeat (DIV + 3 * DIV + DIV / 2) @(negedge clk);
        chk("t6_bit3_low", int'(tx[0]), 0);
        rst = 1'b1;
        #1;
        chk("t6_tx_async_high", int'(tx[0]), 1);
        chk("t6_lev_clear", int'(lev1) + int'(lev0), 0);
      end
    join
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold[1] = 1'b0;
    repeat (12 * DIV) @(negedge clk);
    chk("t6_flushed", ng[1], base1);
    base0 = ng[0];
    send(0, 8'h5A);
    wait_n(0, base0 + 1, 30 * DIV);
    chk("t6_count", ng[0], base0 + 1);
    chk("t6_byte_Z", int'(got[0][base0]), 8'h5A);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
